pia_bus_master: RTL



---
 rtl/pia_bus_pkg.sv | 36 +++
 rtl/pia_master_cycle_ctr.sv | 35 +++
 rtl/pia_bus_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pia_bus_pkg.sv
// Shared definitions for the PIA register-bus master: command op codes,
// PIA register map, controller states and counter widths.
package pia_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_WAIT  = 2'b11
  } op_e;

  localparam logic [6:0] ADR_SWCHA  = 7'h00;
  localparam logic [6:0] ADR_SWACNT = 7'h01;
  localparam logic [6:0] ADR_SWCHB  = 7'h02;
  localparam logic [6:0] ADR_SWBCNT = 7'h03;
  localparam logic [6:0] ADR_INTIM  = 7'h04;
  localparam logic [6:0] ADR_INSTAT = 7'h05;
  localparam logic [6:0] ADR_TIM1T  = 7'h14;
  localparam logic [6:0] ADR_TIM8T  = 7'h15;
  localparam logic [6:0] ADR_TIM64T = 7'h16;
  localparam logic [6:0] ADR_T1024T = 7'h17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_GAP,
    ST_WAIT,
    ST_RESP
  } state_e;

  // 18 bits holds 255 x 1024 wait cycles without wrapping.
  localparam int CTR_W      = 18;
  localparam int POLL_CNT_W = 16;

endpackage

// File: rtl/pia_master_cycle_ctr.sv
// Loadable down-counter with a zero flag; times both the poll gap and WAIT
// commands. Load takes priority; decrement stops at zero.
module pia_master_cycle_ctr #(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pia_bus_master.sv
// Command-driven initiator for the PIA register bus (WRITE/READ/POLL/WAIT).
// Define PIA_BUS_MASTER_POLL_TIMEOUT_EN to bound POLL at MAX_POLLS reads.
module pia_bus_master
  import pia_bus_pkg::*;
#(
  parameter int POLL_GAP   = 4,
  parameter int MAX_POLLS  = 256,
  parameter int WAIT_SCALE = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [6:0] cmd_adr_i,
  input  logic [7:0] cmd_dat_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_dat_o,
  output logic       rsp_timeout_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [6:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [6:0]            adr_q, adr_d;
  logic [7:0]            arg_q, arg_d;
  logic [7:0]            rsp_dat_q, rsp_dat_d;
  logic                  rsp_tmo_q, rsp_tmo_d;
  logic [POLL_CNT_W-1:0] poll_cnt_q, poll_cnt_d;

  logic             accept;
  logic             poll_match;
  logic             poll_exhausted;
  logic             ctr_load;
  logic             ctr_dec;
  logic             ctr_zero;
  logic [CTR_W-1:0] ctr_load_val;
  logic [CTR_W-1:0] wait_cycles;

  assign accept      = cmd_valid_i && (state_q == ST_IDLE);
  assign wait_cycles = CTR_W'(cmd_dat_i) * CTR_W'(WAIT_SCALE);
  // A zero mask means "any value", so the first read always completes.
  assign poll_match  = (arg_q == 8'd0) || ((dat_i & arg_q) != 8'd0);

`ifdef PIA_BUS_MASTER_POLL_TIMEOUT_EN
  assign poll_exhausted = (({1'b0, poll_cnt_q} + (POLL_CNT_W+1)'(1))
                           >= (POLL_CNT_W+1)'(MAX_POLLS));
`else
  assign poll_exhausted = 1'b0;
`endif

  assign ctr_dec = (state_q == ST_GAP) || (state_q == ST_WAIT);

  pia_master_cycle_ctr #(
    .W(CTR_W)
  ) u_cycle_ctr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter is loaded with N-1 so that exactly N cycles are spent in GAP/WAIT.
  always_comb begin
    state_d      = state_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_e'(cmd_op_i) == OP_WAIT) begin
            if (wait_cycles == '0) begin
              state_d = ST_RESP;
            end else begin
              state_d      = ST_WAIT;
              ctr_load     = 1'b1;
              ctr_load_val = wait_cycles - 1'b1;
            end
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = (op_q == OP_WRITE) ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if ((op_q != OP_POLL) || poll_match || poll_exhausted) begin
          state_d = ST_RESP;
        end else if (POLL_GAP == 0) begin
          state_d = ST_ISSUE;
        end else begin
          state_d      = ST_GAP;
          ctr_load     = 1'b1;
          ctr_load_val = CTR_W'(POLL_GAP - 1);
        end
      end
      ST_GAP: begin
        if (ctr_zero) state_d = ST_ISSUE;
      end
      ST_WAIT: begin
        if (ctr_zero) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    adr_d      = adr_q;
    arg_d      = arg_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_tmo_d  = rsp_tmo_q;
    poll_cnt_d = poll_cnt_q;
    if (accept) begin
      op_d       = op_e'(cmd_op_i);
      adr_d      = cmd_adr_i;
      arg_d      = cmd_dat_i;
      rsp_dat_d  = 8'd0;
      rsp_tmo_d  = 1'b0;
      poll_cnt_d = '0;
    end else if (state_q == ST_CAPTURE) begin
      rsp_dat_d = dat_i;
      if ({16'd0, poll_cnt_q} < 32'(MAX_POLLS)) begin
        poll_cnt_d = poll_cnt_q + 1'b1;
      end
      if ((op_q == OP_POLL) && !poll_match && poll_exhausted) begin
        rsp_tmo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= OP_WRITE;
      adr_q      <= '0;
      arg_q      <= '0;
      rsp_dat_q  <= '0;
      rsp_tmo_q  <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      op_q       <= op_d;
      adr_q      <= adr_d;
      arg_q      <= arg_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_tmo_q  <= rsp_tmo_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  always_comb begin
    cmd_ready_o   = rst_ni && (state_q == ST_IDLE);
    stb_o         = (state_q == ST_ISSUE);
    we_o          = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
    adr_o         = (state_q == ST_ISSUE) ? adr_q : 7'd0;
    dat_o         = ((state_q == ST_ISSUE) && (op_q == OP_WRITE)) ? arg_q : 8'd0;
    rsp_valid_o   = (state_q == ST_RESP);
    rsp_dat_o     = (state_q == ST_RESP) ? rsp_dat_q : 8'd0;
    rsp_timeout_o = (state_q == ST_RESP) && rsp_tmo_q;
  end

endmodule
